// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The 64-bit result is computed when the operation is issued and held in a
// pending register. It is copied to HI/LO only when the busy window ends,
// which gives the pipeline a fixed, predictable latency.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | unit free; accepts mult/multu/div/divu issue or mthi/mtlo
// ST_BUSY | counting down; pending result commits on the edge where cnt==1

module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_wr;

   logic          is_arith;
   logic          is_div;
   logic          div_zero;
   logic [63:0]   res;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   divisor_u;
   logic [31:0]   sq_mag;
   logic [31:0]   sr_mag;
   logic [31:0]   sq;
   logic [31:0]   sr;
   logic [31:0]   uq;
   logic [31:0]   ur;

   assign is_arith  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign div_zero  = is_div && (src_b == 32'd0);

   // The issue cycle stalls D too, so the stall does not wait for busy
   assign stall_req = d_md_use & (busy | is_arith);

   // Result datapath; signed divide runs on magnitudes so that
   // 0x80000000 / -1 is well defined (quotient wraps, remainder 0)
   always_comb begin
      prod_s    = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      prod_u    = {32'd0, src_a} * {32'd0, src_b};
      a_mag     = src_a[31] ? (~src_a + 32'd1) : src_a;
      b_mag     = src_b[31] ? (~src_b + 32'd1) : src_b;
      if (b_mag == 32'd0) begin
         b_mag = 32'd1;
      end
      divisor_u = (src_b == 32'd0) ? 32'd1 : src_b;
      sq_mag    = a_mag / b_mag;
      sr_mag    = a_mag % b_mag;
      sq        = (src_a[31] ^ src_b[31]) ? (~sq_mag + 32'd1) : sq_mag;
      sr        = src_a[31] ? (~sr_mag + 32'd1) : sr_mag;
      uq        = src_a / divisor_u;
      ur        = src_a % divisor_u;
      res       = 64'd0;
      case (md_op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = {sr, sq};
         OP_DIVU:  res = {ur, uq};
         default:  res = 64'd0;
      endcase
   end

   // Sequencer: issue, countdown, commit, and direct HI/LO writes
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         hi_out  <= 32'd0;
         lo_out  <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_arith) begin
                  pend_hi <= res[63:32];
                  pend_lo <= res[31:0];
                  pend_wr <= ~div_zero;
                  cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
                  busy    <= 1'b1;
                  state   <= ST_BUSY;
               end else if (md_op == OP_MTHI) begin
                  hi_out  <= src_a;
               end else if (md_op == OP_MTLO) begin
                  lo_out  <= src_a;
               end
            end
            ST_BUSY: begin
               if (cnt == CNT_ONE) begin
                  if (pend_wr) begin
                     hi_out <= pend_hi;
                     lo_out <= pend_lo;
                  end
                  pend_wr <= 1'b0;
                  cnt     <= '0;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end else if (cnt != '0) begin
                  cnt     <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage beside the ALU.
- Sequences mult/multu/div/divu over a fixed number of cycles.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Raises a stall request to the hazard logic while a D-stage instruction needs the unit and the unit is occupied.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after a mult/multu issue (≥1).
- DIV_CYCLES, 10, cycles busy is high after a div/divu issue (≥1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- md_op  in  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- src_a  in  32  forwarded rs value from E stage.
- src_b  in  32  forwarded rt value from E stage.
- d_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress (registered).
- stall_req  out  1  stall D (combinational).
- hi_out  out  32  architectural HI (registered).
- lo_out  out  32  architectural LO (registered).

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - busy=0, HI=0, LO=0, counter=0, pending result cleared.
  - Reset overrides any issue or mt write on the same edge.
  - An operation in flight is abandoned and its result is never committed.
- Issue:
  - Occurs at an edge where md_op ∈ {001..100} and busy=0.
  - src_a and src_b are latched and the 64-bit result is computed into internal pending_hi/pending_lo.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy becomes 1 from the next cycle.
- Operation in flight:
  - Counter decrements each cycle while busy=1.
  - On the edge where counter==1: HI/LO ← pending, busy ← 0, counter ← 0.
  - Net timing: busy is high for exactly N cycles, and the new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32×32→64, HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64, same split.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (div/divu with src_b=0):
  - Timing is unchanged: busy is high for DIV_CYCLES.
  - HI/LO retain their prior values; nothing is committed.
- mthi/mtlo:
  - Applied only when busy=0: HI (or LO) ← src_a at the edge, with no busy cycle.
- Ops while busy:
  - md_op ≠ 000 while busy=1 is ignored.
  - Hazard logic guarantees this never happens; the bench checks it has no effect.
- hi_out/lo_out:
  - Always reflect the registers.
  - mfhi/mflo data is taken from them by the E-stage result mux.
- stall_req = d_md_use & (busy | (md_op ∈ {001..100})).
  - The issue cycle itself stalls D.
  - stall_req is purely combinational, with no latency.
- md_op 000/111 with busy=0: no state change.
- The counter never underflows and never wraps.

Test Plan:
- Signed mult: mult src_a=0xFFFFFFFF, src_b=0x00000002.
  - busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned mult: multu with the same operands.
  - HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Division, signed and unsigned:
  - div src_a=0xFFFFFFF9 (−7), src_b=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2: LO=3, HI=1.
- Divide by zero: preload HI=0x11 and LO=0x22 via mthi/mtlo, then div src_b=0.
  - busy for 10 cycles.
  - HI=0x11 and LO=0x22 unchanged.
- Stall and ignored ops:
  - d_md_use=1 with the mult issued: stall_req=1 in the issue cycle and all 5 busy cycles, 0 once busy drops.
  - d_md_use=0: stall_req=0 throughout.
  - mtlo issued while busy=1 is ignored.
- Reset mid-operation: reset=1 on the 3rd busy cycle of a div.
  - Next cycle busy=0, HI=LO=0.
  - No later commit of the abandoned result.
  - A new mult issued afterwards completes normally.
